mcfir: RTL and testbench
========================

MCFIR -- requirements
Module: mcfir

Interface
REQ-001 SHALL have parameter NTAPS, default 16, taps per channel (power of two, >=2).
REQ-002 SHALL have parameter NCHAN, default 4, interleaved channels (power of two, >=1).
REQ-003 SHALL have parameter IW, default 12, signed sample width.
REQ-004 SHALL have parameter TW, default IW, signed tap width.
REQ-005 SHALL have parameter OW, default IW+TW+$clog2(NTAPS), signed result width.
REQ-006 SHALL have i_clk, input, 1, the single clock.
REQ-007 SHALL have i_reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have i_tap_wr, input, 1, tap shift-in strobe.
REQ-009 SHALL have i_tap, input, TW, tap value.
REQ-010 SHALL have i_valid, input, 1, sample offered.
REQ-011 SHALL have o_ready, output, 1, sample accepted when high with i_valid.
REQ-012 SHALL have i_chan, input, $clog2(NCHAN) (min 1), sample channel.
REQ-013 SHALL have i_sample, input, IW, signed sample.
REQ-014 SHALL have o_valid, output, 1, result available.
REQ-015 SHALL have i_ready, input, 1, downstream accepts result.
REQ-016 SHALL have o_chan, output, $clog2(NCHAN) (min 1), result channel.
REQ-017 SHALL have o_result, output, OW, signed filter output.

Function
REQ-018 SHALL use one shared tap set h[0..NTAPS-1]; an accepted i_tap_wr shifts h[k]<=h[k-1], h[0]<=i_tap.
REQ-019 SHALL accept i_tap_wr only in IDLE; strobes in MAC or OUT are dropped.
REQ-020 SHALL keep per-channel circular history x_c[0..NTAPS-1] with per-channel write pointer wrapping NTAPS-1 -> 0.
REQ-021 SHALL use FSM IDLE -> MAC on i_valid&&o_ready; MAC -> OUT after last product accumulated; OUT -> IDLE on o_valid&&i_ready.
REQ-022 SHALL drive o_ready=1 only in IDLE; o_valid=1 only in OUT.
REQ-023 SHALL on accept write i_sample into x_c at its pointer, then advance the pointer.
REQ-024 SHALL compute y = sum_k h[k]*x_c[n-k], x_c[n] newest; one registered product per cycle, single multiplier.
REQ-025 SHALL accumulate in AW=IW+TW+$clog2(NTAPS) bits with sign extension; no internal overflow.
REQ-026 SHALL assert o_valid exactly NTAPS+2 cycles after the accept edge.
REQ-027 SHALL hold o_valid, o_chan, o_result stable while i_ready=0.
REQ-028 SHALL ignore i_valid outside IDLE; no sample queued.
REQ-029 SHALL, when OW>=AW, sign-extend acc; when OW<AW, apply REQ-036.

Reset
REQ-030 SHALL on i_reset asynchronously force IDLE, o_valid=0, o_ready=0 while asserted, o_result=0, o_chan=0.
REQ-031 SHALL on reset clear all taps, all histories, all pointers, the accumulator.
REQ-032 SHALL abort any MAC/OUT on reset; no result emitted for an aborted sample.
REQ-033 SHALL raise o_ready the first cycle after reset deasserts.

Configuration
REQ-034 SHALL honour macro MCFIR_SATURATE_EN.
REQ-035 SHALL without it (OW<AW) output acc[OW-1:0] (wrap).
REQ-036 SHALL with it (OW<AW) clamp acc to [-2^(OW-1), 2^(OW-1)-1].

Structure
REQ-037 SHALL put FSM state enum and AW function in package mcfir_pkg.
REQ-038 SHALL use sub-module mcfir_mac (registered multiply, accumulate, clear).

Verification (NTAPS=4, NCHAN=2, IW=TW=12, AW=26)
REQ-039 SHALL: taps written 4,3,2,1 (h=1,2,3,4); ch0 samples 1,0,0,0,0 -> results 1,2,3,4,0, each NTAPS+2 cycles after accept.
REQ-040 SHALL: same taps; interleave ch0 impulse with ch1 samples all 2 -> ch1 outputs 2,6,12,20,20; ch0 outputs unchanged from REQ-039.
REQ-041 SHALL: i_ready=0 for 10 cycles in OUT -> o_valid, o_chan, o_result constant, o_ready=0, offered i_valid ignored.
REQ-042 SHALL: all taps and four samples -2048, OW=16 -> acc 16777216; output 32767 with MCFIR_SATURATE_EN, 0 without.
REQ-043 SHALL: i_reset pulse mid-MAC -> o_valid stays 0; next impulse with no tap writes -> result 0.
REQ-044 SHALL: i_tap_wr in MAC -> taps unchanged; following impulse still yields 1,2,3,4.

Source files
------------

// File: rtl/mcfir_pkg.sv
// Shared definitions for the multi-channel FIR: controller states and width helpers.
package mcfir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Accumulator width large enough that NTAPS full-scale products never overflow.
    function automatic int mcfir_aw(input int iw, input int tw, input int ntaps);
        return iw + tw + $clog2(ntaps);
    endfunction

    function automatic int mcfir_cw(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

// File: rtl/mcfir_if.sv
// Sample-in / result-out bus of the multi-channel FIR, plus tap loading and state debug.
interface mcfir_if
    import mcfir_pkg::*;
#(
    parameter int IW = 12,
    parameter int TW = 12,
    parameter int OW = 28,
    parameter int CW = 2
);
    // Handshakes: a transfer happens on a rising clock edge where valid && ready are
    // both high; the producer holds valid and its payload stable until that edge, and
    // valid never depends combinationally on ready.
    logic                 i_tap_wr;
    logic signed [TW-1:0] i_tap;
    logic                 i_valid;
    logic                 o_ready;
    logic [CW-1:0]        i_chan;
    logic signed [IW-1:0] i_sample;
    logic                 o_valid;
    logic                 i_ready;
    logic [CW-1:0]        o_chan;
    logic signed [OW-1:0] o_result;
    state_t               dbg_state;

    modport slave (
        input  i_tap_wr, i_tap, i_valid, i_chan, i_sample, i_ready,
        output o_ready, o_valid, o_chan, o_result, dbg_state
    );

    modport master (
        output i_tap_wr, i_tap, i_valid, i_chan, i_sample, i_ready,
        input  o_ready, o_valid, o_chan, o_result, dbg_state
    );
endinterface

// File: rtl/mcfir_mac.sv
// Single multiplier with a registered product feeding a clearable sign-extending accumulator.
module mcfir_mac #(
    parameter int IW = 12,
    parameter int TW = 12,
    parameter int AW = 28
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic signed [TW-1:0] i_tap,
    input  logic signed [IW-1:0] i_sample,
    output logic signed [AW-1:0] o_acc
);
    logic signed [IW+TW-1:0] prod_q;
    logic                    prod_vld_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            o_acc      <= '0;
        end else if (i_clear) begin
            prod_vld_q <= 1'b0;
            o_acc      <= '0;
        end else begin
            prod_vld_q <= i_en;
            if (i_en) prod_q <= i_tap * i_sample;
            if (prod_vld_q) o_acc <= o_acc + AW'(prod_q);
        end
    end
endmodule

// File: rtl/mcfir.sv
// Time-multiplexed FIR over NCHAN interleaved channels sharing one tap set and one multiplier.
// Build option MCFIR_SATURATE_EN: clamp instead of wrap when OW is narrower than the accumulator.
module mcfir
    import mcfir_pkg::*;
#(
    parameter int NTAPS = 16,
    parameter int NCHAN = 4,
    parameter int IW    = 12,
    parameter int TW    = IW,
    parameter int OW    = IW + TW + $clog2(NTAPS)
) (
    input logic   i_clk,
    input logic   i_reset,
    mcfir_if.slave bus
);
    localparam int AW = mcfir_aw(IW, TW, NTAPS);
    localparam int CW = mcfir_cw(NCHAN);
    localparam int PW = $clog2(NTAPS);
    localparam int KW = PW + 1;

    state_t               state_q, state_d;
    logic [KW-1:0]        cnt_q;
    logic signed [TW-1:0] taps [NTAPS];
    logic signed [IW-1:0] hist [NCHAN][NTAPS];
    logic [PW-1:0]        wptr [NCHAN];
    logic [PW-1:0]        base_q;
    logic [CW-1:0]        chan_q;
    logic [PW-1:0]        rd_idx;
    logic signed [AW-1:0] acc;
    logic signed [OW-1:0] res_next;
    logic                 ready_c, valid_c;
    logic                 accept, tap_acc, mac_en, mac_last;

    assign accept   = bus.i_valid && ready_c;
    assign tap_acc  = bus.i_tap_wr && (state_q == S_IDLE);
    assign mac_en   = (state_q == S_MAC) && (cnt_q < KW'(NTAPS));
    assign mac_last = (state_q == S_MAC) && (cnt_q == KW'(NTAPS + 1));
    // Product k pairs h[k] with the sample k steps older than the one just accepted.
    assign rd_idx   = base_q - cnt_q[PW-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        valid_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_c = !i_reset;
                if (bus.i_valid && !i_reset) state_d = S_MAC;
            end
            S_MAC: begin
                if (cnt_q == KW'(NTAPS + 1)) state_d = S_OUT;
            end
            S_OUT: begin
                valid_c = 1'b1;
                if (bus.i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready   = ready_c;
    assign bus.o_valid   = valid_c;
    assign bus.dbg_state = state_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= '0;
            base_q <= '0;
            chan_q <= '0;
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                wptr[c] <= '0;
                for (int k = 0; k < NTAPS; k++) hist[c][k] <= '0;
            end
        end else begin
            if (tap_acc) begin
                for (int k = NTAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
                taps[0] <= bus.i_tap;
            end
            if (accept) begin
                hist[bus.i_chan][wptr[bus.i_chan]] <= bus.i_sample;
                wptr[bus.i_chan] <= wptr[bus.i_chan] + 1'b1;
                base_q <= wptr[bus.i_chan];
                chan_q <= bus.i_chan;
                cnt_q  <= '0;
            end else if (state_q == S_MAC) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    mcfir_mac #(.IW(IW), .TW(TW), .AW(AW)) u_mac (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (accept),
        .i_en     (mac_en),
        .i_tap    (taps[cnt_q[PW-1:0]]),
        .i_sample (hist[chan_q][rd_idx]),
        .o_acc    (acc)
    );

    generate
        if (OW >= AW) begin : g_extend
            assign res_next = OW'(acc);
        end else begin : g_narrow
`ifdef MCFIR_SATURATE_EN
            localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            always_comb begin
                res_next = acc[OW-1:0];
                if (acc > MAXV)      res_next = {1'b0, {(OW-1){1'b1}}};
                else if (acc < MINV) res_next = {1'b1, {(OW-1){1'b0}}};
            end
`else
            assign res_next = acc[OW-1:0];
`endif
        end
    endgenerate

    // Result registers only load on the MAC->OUT transition, so they hold through a stall.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus.o_result <= '0;
            bus.o_chan   <= '0;
        end else if (mac_last) begin
            bus.o_result <= res_next;
            bus.o_chan   <= chan_q;
        end
    end
endmodule

// File: tb/tb_mcfir.sv
// Directed bench for mcfir with NTAPS=4, NCHAN=2, IW=TW=12, OW=16.
module tb_mcfir;
    import mcfir_pkg::*;

    localparam int NTAPS = 4;
    localparam int NCHAN = 2;
    localparam int IW    = 12;
    localparam int TW    = 12;
    localparam int OW    = 16;
    localparam int CW    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    mcfir_if #(.IW(IW), .TW(TW), .OW(OW), .CW(CW)) bus ();

    mcfir #(.NTAPS(NTAPS), .NCHAN(NCHAN), .IW(IW), .TW(TW), .OW(OW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_tap(input int v);
        bus.i_tap    = TW'(v);
        bus.i_tap_wr = 1'b1;
        @(posedge clk); #1;
        bus.i_tap_wr = 1'b0;
    endtask

    // Offer one sample, then time and check the result; optionally strobe tap writes meanwhile.
    task automatic send(input int ch, input int smp, input int exp_r, input bit chk_r,
                        input bit stuff, input string tag);
        int n;
        bus.i_chan   = CW'(ch);
        bus.i_sample = IW'(smp);
        bus.i_valid  = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, bus.o_ready, 1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        if (stuff) begin
            bus.i_tap    = TW'(9);
            bus.i_tap_wr = 1'b1;
        end
        n = 0;
        while (!bus.o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bus.i_tap_wr = 1'b0;
        chk({tag, "_lat"}, n, NTAPS + 2);
        chk({tag, "_chan"}, bus.o_chan, ch);
        if (chk_r) chk({tag, "_res"}, bus.o_result, exp_r);
        @(posedge clk); #1;
        chk({tag, "_done"}, bus.o_valid, 0);
    endtask

    initial begin
        int ch0_exp [5];
        int ch1_exp [5];
        int seen;
        int sat_exp;
        ch0_exp = '{1, 2, 3, 4, 0};
        ch1_exp = '{2, 6, 12, 20, 20};
`ifdef MCFIR_SATURATE_EN
        sat_exp = 32767;
`else
        sat_exp = 0;
`endif
        bus.i_tap_wr = 1'b0;
        bus.i_tap    = '0;
        bus.i_valid  = 1'b0;
        bus.i_chan   = '0;
        bus.i_sample = '0;
        bus.i_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_chan", bus.o_chan, 0);
        chk("rst_state", bus.dbg_state, S_IDLE);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", bus.o_ready, 1);

        // Impulse response on channel 0
        write_tap(4); write_tap(3); write_tap(2); write_tap(1);
        send(0, 1, ch0_exp[0], 1, 0, "imp0");
        for (int i = 1; i < 5; i++) send(0, 0, ch0_exp[i], 1, 0, $sformatf("imp%0d", i));

        // Interleaved channels: ch0 impulse again, ch1 constant 2
        for (int i = 0; i < 5; i++) begin
            send(0, (i == 0) ? 1 : 0, ch0_exp[i], 1, 0, $sformatf("il0_%0d", i));
            send(1, 2, ch1_exp[i], 1, 0, $sformatf("il1_%0d", i));
        end

        // Output stall with a competing sample offered
        bus.i_ready  = 1'b0;
        bus.i_chan   = 1'b0;
        bus.i_sample = IW'(5);
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        seen = 0;
        while (!bus.o_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("stall_lat", seen, NTAPS + 2);
        bus.i_chan   = 1'b1;
        bus.i_sample = IW'(100);
        bus.i_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_valid%0d", i), bus.o_valid, 1);
            chk($sformatf("stall_chan%0d", i), bus.o_chan, 0);
            chk($sformatf("stall_res%0d", i), bus.o_result, 5);
            chk($sformatf("stall_ready%0d", i), bus.o_ready, 0);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", bus.o_valid, 0);
        chk("stall_idle", bus.dbg_state, S_IDLE);
        send(1, 2, 20, 1, 0, "stall_after");

        // Full-scale negative taps and samples overflow a 16-bit output
        for (int i = 0; i < 4; i++) write_tap(-2048);
        for (int i = 0; i < 3; i++) send(0, -2048, 0, 0, 0, $sformatf("fs%0d", i));
        send(0, -2048, sat_exp, 1, 0, "fs_full");

        // Reset in the middle of a MAC
        bus.i_chan   = 1'b0;
        bus.i_sample = IW'(1);
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_in_mac", bus.dbg_state, S_MAC);
        rst = 1'b1;
        #1;
        chk("abort_ready", bus.o_ready, 0);
        chk("abort_state", bus.dbg_state, S_IDLE);
        chk("abort_result", bus.o_result, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_ready_after", bus.o_ready, 1);
        seen = 0;
        for (int i = 0; i < NTAPS + 6; i++) begin
            @(posedge clk); #1;
            if (bus.o_valid) seen++;
        end
        chk("abort_no_out", seen, 0);
        send(1, 1, 0, 1, 0, "abort_imp");

        // Tap strobes during MAC/OUT are dropped
        write_tap(4); write_tap(3); write_tap(2); write_tap(1);
        send(0, 1, 1, 1, 1, "tapdrop0");
        for (int i = 1; i < 4; i++) send(0, 0, i + 1, 1, 0, $sformatf("tapdrop%0d", i));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
